// File: rtl/matrix_stream_feeder_if.sv
// Element-stream and packed-word handshake bundle between the feeder and its neighbours.
// The master modport is the feeder; the slave modport is the element source / multiplier side.
interface matrix_stream_feeder_if #(
    parameter int WIDTH        = 8,
    parameter int NUM_ELEMENTS = 4
);
    logic [WIDTH-1:0]              in_data;
    logic                          in_valid;
    logic                          in_ready;
    logic [NUM_ELEMENTS*WIDTH-1:0] wdata;
    logic                          w_en;
    logic                          w_ready;
    logic                          busy;
    logic                          done;

    modport master (
        input  in_data, in_valid, w_ready,
        output in_ready, wdata, w_en, busy, done
    );

    modport slave (
        output in_data, in_valid, w_ready,
        input  in_ready, wdata, w_en, busy, done
    );
endinterface

// File: rtl/matrix_stream_feeder.sv
// Buffers an A/B operand element stream and emits packed column-pair words to the multiplier.
// Defining MATRIX_STREAM_FEEDER_CNT_EN adds the pair_cnt completed-pair counter output.
//
// state | meaning
// LOAD  | accepting elements into the buffer (in_ready=1)
// SEND  | presenting packed words under w_ready back-pressure (busy=1)
module matrix_stream_feeder #(
    parameter int WIDTH        = 8,
    parameter int MATRIX_WIDTH = 4,
    parameter int NUM_ELEMENTS = 4
) (
    input  logic w_clk,
    input  logic w_reset_n,
`ifdef MATRIX_STREAM_FEEDER_CNT_EN
    output logic [15:0] pair_cnt,
`endif
    matrix_stream_feeder_if.master bus
);
    localparam int N     = MATRIX_WIDTH;
    localparam int ELEMS = N * N;
    localparam int CW    = $clog2(2 * ELEMS);
    localparam int CLW   = $clog2(N);
    localparam int RPW   = (N > 2) ? $clog2(N / 2) : 1;
    localparam logic [CW-1:0]  LAST_ELEM = CW'(2 * ELEMS - 1);
    localparam logic [CLW-1:0] LAST_COL  = CLW'(N - 1);
    localparam logic [RPW-1:0] LAST_RP   = RPW'(N / 2 - 1);

    typedef enum logic {ST_LOAD, ST_SEND} state_t;

    state_t                        state_q, state_n;
    logic [CW-1:0]                 elem_cnt_q, elem_cnt_n;
    logic [CLW-1:0]                col_q, col_n;
    logic [RPW-1:0]                rp_q, rp_n;
    logic                          in_ready_q, in_ready_n;
    logic                          w_en_q, w_en_n;
    logic                          busy_q, busy_n;
    logic                          done_q, done_n;
    logic [NUM_ELEMENTS*WIDTH-1:0] wdata_q, wdata_n;
    logic [NUM_ELEMENTS*WIDTH-1:0] word_nxt;
    logic                          elem_wr;

    // A occupies entries 0..ELEMS-1 and B the rest, both row-major, so the
    // element counter doubles as the write address.
    logic [WIDTH-1:0] mem [2*ELEMS];

    always_ff @(posedge w_clk) begin
        if (elem_wr) mem[elem_cnt_q] <= bus.in_data;
    end

    // Word addressed by the counters' next value; in LOAD these stay at 0,
    // so the word registered on entry to SEND is the first one.
    always_comb begin
        int c;
        int r;
        c = int'(col_n);
        r = 2 * int'(rp_n);
        word_nxt = {mem[CW'(r * N + c)], mem[CW'((r + 1) * N + c)],
                    mem[CW'(ELEMS + r * N + c)], mem[CW'(ELEMS + (r + 1) * N + c)]};
    end

    always_comb begin
        state_n    = state_q;
        elem_cnt_n = elem_cnt_q;
        col_n      = col_q;
        rp_n       = rp_q;
        in_ready_n = in_ready_q;
        w_en_n     = w_en_q;
        busy_n     = busy_q;
        done_n     = 1'b0;
        wdata_n    = wdata_q;
        elem_wr    = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (bus.in_valid && in_ready_q) begin
                    elem_wr = 1'b1;
                    if (elem_cnt_q == LAST_ELEM) begin
                        state_n    = ST_SEND;
                        elem_cnt_n = '0;
                        in_ready_n = 1'b0;
                        w_en_n     = 1'b1;
                        busy_n     = 1'b1;
                        wdata_n    = word_nxt;
                    end else begin
                        elem_cnt_n = elem_cnt_q + CW'(1);
                    end
                end
            end
            ST_SEND: begin
                if (bus.w_ready) begin
                    if (col_q == LAST_COL && rp_q == LAST_RP) begin
                        state_n    = ST_LOAD;
                        col_n      = '0;
                        rp_n       = '0;
                        in_ready_n = 1'b1;
                        w_en_n     = 1'b0;
                        busy_n     = 1'b0;
                        done_n     = 1'b1;
                    end else begin
                        if (rp_q == LAST_RP) begin
                            rp_n  = '0;
                            col_n = col_q + CLW'(1);
                        end else begin
                            rp_n = rp_q + RPW'(1);
                        end
                        wdata_n = word_nxt;
                    end
                end
            end
            default: state_n = ST_LOAD;
        endcase
    end

    always_ff @(posedge w_clk) begin
        if (!w_reset_n) begin
            state_q    <= ST_LOAD;
            elem_cnt_q <= '0;
            col_q      <= '0;
            rp_q       <= '0;
            in_ready_q <= 1'b1;
            w_en_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_n;
            elem_cnt_q <= elem_cnt_n;
            col_q      <= col_n;
            rp_q       <= rp_n;
            in_ready_q <= in_ready_n;
            w_en_q     <= w_en_n;
            busy_q     <= busy_n;
            done_q     <= done_n;
            wdata_q    <= wdata_n;
        end
    end

`ifdef MATRIX_STREAM_FEEDER_CNT_EN
    always_ff @(posedge w_clk) begin
        if (!w_reset_n)  pair_cnt <= '0;
        else if (done_n) pair_cnt <= pair_cnt + 16'd1;
    end
`endif

    assign bus.in_ready = in_ready_q;
    assign bus.w_en     = w_en_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.wdata    = wdata_q;
endmodule

// File: tb/tb_matrix_stream_feeder.sv
// Directed bench for matrix_stream_feeder: table-driven word/handshake vectors plus
// hand-written reset, back-to-back and idle sequences.
module tb_matrix_stream_feeder;
    localparam int WIDTH = 8;
    localparam int N     = 4;
    localparam int NE    = 4;

    logic w_clk     = 1'b0;
    logic w_reset_n = 1'b0;

    matrix_stream_feeder_if #(.WIDTH(WIDTH), .NUM_ELEMENTS(NE)) bus ();
`ifdef MATRIX_STREAM_FEEDER_CNT_EN
    logic [15:0] pair_cnt;
`endif

    matrix_stream_feeder #(.WIDTH(WIDTH), .MATRIX_WIDTH(N), .NUM_ELEMENTS(NE)) dut (
        .w_clk     (w_clk),
        .w_reset_n (w_reset_n),
`ifdef MATRIX_STREAM_FEEDER_CNT_EN
        .pair_cnt  (pair_cnt),
`endif
        .bus       (bus)
    );

    always #5 w_clk = ~w_clk;

    typedef struct packed {
        logic        reload;
        logic        w_ready;
        logic [3:0]  exp_ctl;   // {w_en, busy, done, in_ready}
        logic        chk_wdata;
        logic [31:0] exp_wdata;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge w_clk);
        #1;
    endtask

    function automatic logic [7:0] elem_val(input int e, input bit uniform);
        if (uniform) return (e < 16) ? 8'h11 : 8'h22;
        if (e < 16) return 8'(e + 1);
        return 8'(8'h80 + e - 16);
    endfunction

    // Streams elements first..31 one per cycle; in_ready must be high and w_en low at each.
    task automatic load_pair(input bit uniform, input int first, input bit keep_valid);
        int bad;
        bad = 0;
        for (int e = first; e < 2 * N * N; e++) begin
            bus.in_data  = elem_val(e, uniform);
            bus.in_valid = 1'b1;
            if (bus.in_ready !== 1'b1 || bus.w_en !== 1'b0) bad++;
            tick();
        end
        if (!keep_valid) bus.in_valid = 1'b0;
        check("load_handshake", bad, 0);
    endtask

    logic [31:0] words [8];
    vec_t        vecs [$];

    initial begin
        int bad;
        int cyc;
        int t;
        logic wr;

        words = '{32'h01058084, 32'h090D888C, 32'h02068185, 32'h0A0E898D,
                  32'h03078286, 32'h0B0F8A8E, 32'h04088387, 32'h0C108B8F};

        // Full throughput pass.
        for (int k = 0; k < 8; k++)
            vecs.push_back('{k == 0, 1'b1, 4'b1100, 1'b1, words[k]});
        vecs.push_back('{1'b0, 1'b1, 4'b0011, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 4'b0001, 1'b0, 32'h0});
        // Stalled pass, w_ready pattern 1,0,0 repeating.
        t = 0;
        for (int k = 0; k < 8; k++) begin
            do begin
                wr = (t % 3 == 0);
                vecs.push_back('{k == 0, wr, 4'b1100, 1'b1, words[k]});
                t++;
            end while (!wr);
        end
        vecs.push_back('{1'b0, 1'b0, 4'b0011, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b0, 4'b0001, 1'b0, 32'h0});

        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        bus.w_ready  = 1'b1;
        w_reset_n    = 1'b0;
        tick();
        tick();
        w_reset_n = 1'b1;

        check("reset_ctl", {bus.w_en, bus.busy, bus.done, bus.in_ready}, 4'b0001);
        check("reset_wdata", bus.wdata, 32'h0);
`ifdef MATRIX_STREAM_FEEDER_CNT_EN
        check("reset_pair_cnt", pair_cnt, 16'd0);
`endif

        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus.w_en !== 1'b0 || bus.in_ready !== 1'b1) bad++;
            tick();
        end
        check("idle_50", bad, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].reload) begin
                bus.w_ready = 1'b1;
                load_pair(1'b0, 0, 1'b0);
            end
            bus.w_ready = vecs[i].w_ready;
            check($sformatf("vec%0d_ctl", i), {bus.w_en, bus.busy, bus.done, bus.in_ready},
                  vecs[i].exp_ctl);
            if (vecs[i].chk_wdata)
                check($sformatf("vec%0d_wdata", i), bus.wdata, vecs[i].exp_wdata);
            tick();
        end

        // Reset mid-SEND after three words.
        bus.w_ready = 1'b1;
        load_pair(1'b0, 0, 1'b0);
        tick();
        tick();
        tick();
        check("pre_reset_word", bus.wdata, words[3]);
        w_reset_n = 1'b0;
        tick();
        w_reset_n = 1'b1;
        check("send_reset_ctl", {bus.w_en, bus.busy, bus.done, bus.in_ready}, 4'b0001);
        check("send_reset_wdata", bus.wdata, 32'h0);
`ifdef MATRIX_STREAM_FEEDER_CNT_EN
        check("send_reset_pair_cnt", pair_cnt, 16'd0);
`endif

        // Reset mid-LOAD discards a partial load.
        for (int i = 0; i < 5; i++) begin
            bus.in_data  = 8'hEE;
            bus.in_valid = 1'b1;
            tick();
        end
        w_reset_n    = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        w_reset_n = 1'b1;

        // Reload with in_valid held high across the end of load.
        load_pair(1'b0, 0, 1'b1);
        bus.in_data = 8'h11;
        check("reload_word0", bus.wdata, 32'h01058084);
        bad = 0;
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 20) begin
            if (bus.in_ready !== 1'b0) bad++;
            tick();
            cyc++;
        end
        check("send_in_ready_low", bad, 0);
        check("done_seen", bus.done, 1'b1);
        check("send_cycles", cyc, 8);
`ifdef MATRIX_STREAM_FEEDER_CNT_EN
        check("pair_cnt_1", pair_cnt, 16'd1);
`endif
        tick();
        load_pair(1'b1, 1, 1'b0);
        check("pair2_start", {bus.w_en, bus.in_ready}, 2'b10);
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            if (bus.w_en !== 1'b1 || bus.wdata !== 32'h11112222) bad++;
            tick();
        end
        check("pair2_words", bad, 0);
        check("pair2_done", {bus.w_en, bus.done}, 2'b01);
`ifdef MATRIX_STREAM_FEEDER_CNT_EN
        check("pair_cnt_2", pair_cnt, 16'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
